// File: rtl/watch_ctrl_if.sv
// Button, datapath-status and control signals exchanged between the stopwatch
// sequencer (master) and the board/datapath side (slave).
interface watch_ctrl_if;
  logic       btn_start_stop;
  logic       btn_clear;
  logic       btn_lap;
  logic       at_max;
  logic       tick;
  logic       clr;
  logic       freeze;
  logic       running;
  logic [1:0] state;

  modport master (
    input  btn_start_stop, btn_clear, btn_lap, at_max,
    output tick, clr, freeze, running, state
  );

  modport slave (
    output btn_start_stop, btn_clear, btn_lap, at_max,
    input  tick, clr, freeze, running, state
  );
endinterface

// File: rtl/watch_ctrl.sv
// Stopwatch control sequencer: debounced button events, IDLE/RUN/PAUSE/LAP FSM,
// 1 Hz tick prescaler, clear pulse and lap display freeze.
module watch_ctrl #(
    parameter int unsigned CLK_DIV      = 50_000_000,
    parameter int unsigned DEBOUNCE_CYC = 20'd1_000_000,
    parameter int unsigned CNT_W        = 26,
    parameter int unsigned DB_W         = 20
) (
    input logic        clk,
    input logic        rst_n,
    watch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(CLK_DIV - 1);

    // Button lanes: [0] clear, [1] start_stop, [2] lap
    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      acc;
    logic [2:0]      acc_q;
    logic [2:0]      ev;
    logic [DB_W-1:0] db_cnt [3];

    state_t          state;
    logic [CNT_W-1:0] presc;
    logic            tick;
    logic            clr;
    logic            freeze;
    logic            running;

    logic            ev_clr;
    logic            ev_ss;
    logic            ev_lap;
    logic            wrap;

    assign raw = {bus.btn_lap, bus.btn_start_stop, bus.btn_clear};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            acc   <= '0;
            acc_q <= '0;
            for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            acc_q <= acc;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] == acc[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    acc[i]    <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press events only; priority clear > start_stop > lap drops the losers
    assign ev     = acc & ~acc_q;
    assign ev_clr = ev[0];
    assign ev_ss  = ev[1] & ~ev[0];
    assign ev_lap = ev[2] & ~ev[1] & ~ev[0];
    assign wrap   = running && (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            presc   <= '0;
            tick    <= 1'b0;
            clr     <= 1'b0;
            freeze  <= 1'b0;
            running <= 1'b0;
        end else begin
            tick <= 1'b0;
            clr  <= 1'b0;
            if (running) presc <= wrap ? '0 : presc + 1'b1;

            // Saturation swallows the tick and any coincident event
            if (wrap && bus.at_max) begin
                state   <= PAUSE;
                running <= 1'b0;
                freeze  <= 1'b0;
            end else begin
                tick <= wrap;
                if (ev_clr) begin
                    if (state == IDLE || state == PAUSE) begin
                        state <= IDLE;
                        clr   <= 1'b1;
                        presc <= '0;
                    end
                end else if (ev_ss) begin
                    case (state)
                        IDLE: begin
                            state   <= RUN;
                            running <= 1'b1;
                            presc   <= '0;
                        end
                        RUN, LAP: begin
                            state   <= PAUSE;
                            running <= 1'b0;
                            freeze  <= 1'b0;
                        end
                        PAUSE: begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                        default: ;
                    endcase
                end else if (ev_lap) begin
                    case (state)
                        RUN: begin
                            state  <= LAP;
                            freeze <= 1'b1;
                        end
                        LAP: begin
                            state  <= RUN;
                            freeze <= 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.tick    = tick;
    assign bus.clr     = clr;
    assign bus.freeze  = freeze;
    assign bus.running = running;
    assign bus.state   = state;

endmodule

// File: tb/tb_watch_ctrl.sv
// Bench for watch_ctrl: directed scenarios plus random button/at_max activity,
// every cycle compared against a behavioural model of the stopwatch rules.
module tb_watch_ctrl;

    localparam int unsigned CLK_DIV = 10;
    localparam int unsigned DEB     = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    watch_ctrl_if bus ();

    watch_ctrl #(
        .CLK_DIV      (CLK_DIV),
        .DEBOUNCE_CYC (DEB),
        .CNT_W        (4),
        .DB_W         (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: raw-sample history per button, acceptance when the synchronized
    // stream has disagreed with the accepted level for DEB samples in a row.
    int       m_state;
    int       m_presc;
    bit       m_tick;
    bit       m_clr;
    bit [7:0] m_hist [3];
    bit       m_acc [3];
    bit       m_acc_old [3];
    int       m_fresh [3];

    function automatic bit btn_raw(input int i);
        case (i)
            0:       return bus.btn_clear;
            1:       return bus.btn_start_stop;
            default: return bus.btn_lap;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_presc = 0;
        m_tick  = 0;
        m_clr   = 0;
        for (int i = 0; i < 3; i++) begin
            m_hist[i]    = '0;
            m_acc[i]     = 0;
            m_acc_old[i] = 0;
            m_fresh[i]   = DEB;
        end
    endtask

    task automatic model_step();
        bit ev [3];
        bit all_diff;
        bit run;
        bit sat;
        int nst;
        for (int i = 0; i < 3; i++) ev[i] = m_acc[i] && !m_acc_old[i];
        for (int i = 0; i < 3; i++) begin
            m_acc_old[i] = m_acc[i];
            if (m_fresh[i] < 100) m_fresh[i]++;
            all_diff = 1;
            for (int j = 1; j <= int'(DEB); j++)
                if (m_hist[i][j] == m_acc[i]) all_diff = 0;
            if (m_fresh[i] >= int'(DEB) && all_diff) begin
                m_acc[i]   = !m_acc[i];
                m_fresh[i] = 0;
            end
            m_hist[i] = {m_hist[i][6:0], btn_raw(i)};
        end

        run    = (m_state == 1 || m_state == 3);
        sat    = 0;
        nst    = m_state;
        m_tick = 0;
        m_clr  = 0;
        if (run) begin
            if (m_presc == int'(CLK_DIV) - 1) begin
                m_presc = 0;
                if (bus.at_max) begin
                    sat = 1;
                    nst = 2;
                end else begin
                    m_tick = 1;
                end
            end else begin
                m_presc = m_presc + 1;
            end
        end
        if (!sat) begin
            if (ev[0]) begin
                if (m_state == 0 || m_state == 2) begin
                    nst     = 0;
                    m_clr   = 1;
                    m_presc = 0;
                end
            end else if (ev[1]) begin
                if (m_state == 0) begin
                    nst     = 1;
                    m_presc = 0;
                end else if (m_state == 2) nst = 1;
                else nst = 2;
            end else if (ev[2]) begin
                if (m_state == 1) nst = 3;
                else if (m_state == 3) nst = 1;
            end
        end
        m_state = nst;
    endtask

    task automatic compare_all();
        check("tick",    bus.tick,    m_tick);
        check("clr",     bus.clr,     m_clr);
        check("state",   bus.state,   m_state);
        check("running", bus.running, (m_state == 1 || m_state == 3) ? 1 : 0);
        check("freeze",  bus.freeze,  (m_state == 3) ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        bus.btn_start_stop = 1'b0;
        bus.btn_clear      = 1'b0;
        bus.btn_lap        = 1'b0;
        bus.at_max         = 1'b0;
        model_reset();
        idle(3);
        rst_n = 1'b1;
    endtask

    int hold_left [3];

    initial begin
        bus.btn_start_stop = 1'b0;
        bus.btn_clear      = 1'b0;
        bus.btn_lap        = 1'b0;
        bus.at_max         = 1'b0;
        model_reset();

        // Reset state, start latency, tick spacing
        do_reset();
        check("t0_rst_state", bus.state, 0);
        idle(2);
        bus.btn_start_stop = 1'b1;
        idle(6);
        check("t1_pre_run", bus.state, 0);
        idle(1);
        check("t1_run", bus.state, 1);
        bus.btn_start_stop = 1'b0;
        idle(9);
        check("t1_no_early_tick", bus.tick, 0);
        idle(1);
        check("t1_tick1", bus.tick, 1);
        idle(10);
        check("t1_tick2", bus.tick, 1);
        check("t1_running", bus.running, 1);
        check("t1_freeze", bus.freeze, 0);

        // Pause preserves the fractional second
        do_reset();
        bus.btn_start_stop = 1'b1;
        idle(8);
        bus.btn_start_stop = 1'b0;
        idle(15);
        bus.btn_start_stop = 1'b1;
        idle(7);
        check("t2_paused", bus.state, 2);
        bus.btn_start_stop = 1'b0;
        idle(22);
        bus.btn_start_stop = 1'b1;
        idle(7);
        check("t2_resumed", bus.state, 1);
        bus.btn_start_stop = 1'b0;
        idle(6);
        check("t2_no_tick_yet", bus.tick, 0);
        idle(1);
        check("t2_frac_tick", bus.tick, 1);

        // Glitches rejected, stable press accepted, release silent
        do_reset();
        repeat (3) begin
            bus.btn_start_stop = 1'b1;
            idle(2);
            bus.btn_start_stop = 1'b0;
            idle(3);
        end
        check("t3_glitch_idle", bus.state, 0);
        bus.btn_start_stop = 1'b1;
        idle(5);
        bus.btn_start_stop = 1'b0;
        idle(10);
        check("t3_run", bus.state, 1);
        idle(15);
        check("t3_release_no_event", bus.state, 1);

        // Lap in and out
        bus.btn_lap = 1'b1;
        idle(7);
        check("t4_lap", bus.state, 3);
        check("t4_freeze", bus.freeze, 1);
        bus.btn_lap = 1'b0;
        idle(25);
        bus.btn_lap = 1'b1;
        idle(7);
        check("t4_unlap", bus.state, 1);
        check("t4_unfreeze", bus.freeze, 0);
        bus.btn_lap = 1'b0;
        idle(8);

        // Clear + start_stop together in PAUSE; clear ignored in RUN
        bus.btn_start_stop = 1'b1;
        idle(7);
        check("t5_pause", bus.state, 2);
        bus.btn_start_stop = 1'b0;
        idle(8);
        bus.btn_clear      = 1'b1;
        bus.btn_start_stop = 1'b1;
        idle(7);
        check("t5_clr", bus.clr, 1);
        check("t5_idle", bus.state, 0);
        bus.btn_clear      = 1'b0;
        bus.btn_start_stop = 1'b0;
        idle(1);
        check("t5_clr_one_cycle", bus.clr, 0);
        idle(8);
        bus.btn_start_stop = 1'b1;
        idle(7);
        check("t5_run", bus.state, 1);
        bus.btn_start_stop = 1'b0;
        idle(8);
        bus.btn_clear = 1'b1;
        idle(7);
        check("t5_run_clr_ignored", bus.clr, 0);
        check("t5_run_stays", bus.state, 1);
        bus.btn_clear = 1'b0;
        idle(5);

        // Saturation at 99:59:59
        do_reset();
        bus.at_max         = 1'b1;
        bus.btn_start_stop = 1'b1;
        idle(7);
        check("t6_run", bus.state, 1);
        bus.btn_start_stop = 1'b0;
        idle(9);
        check("t6_pre_sat", bus.state, 1);
        idle(1);
        check("t6_sat_no_tick", bus.tick, 0);
        check("t6_sat_pause", bus.state, 2);
        bus.at_max = 1'b0;
        idle(3);
        bus.btn_start_stop = 1'b1;
        idle(7);
        check("t6_resume", bus.state, 1);
        bus.btn_start_stop = 1'b0;
        idle(9);
        check("t6_no_early_tick", bus.tick, 0);
        idle(1);
        check("t6_presc_zero", bus.tick, 1);

        // Asynchronous reset mid-second in LAP
        do_reset();
        bus.btn_start_stop = 1'b1;
        idle(7);
        bus.btn_start_stop = 1'b0;
        idle(8);
        bus.btn_lap = 1'b1;
        idle(7);
        check("t7_lap", bus.state, 3);
        bus.btn_lap = 1'b0;
        idle(4);
        rst_n = 1'b0;
        #1;
        check("t7_rst_state", bus.state, 0);
        check("t7_rst_freeze", bus.freeze, 0);
        check("t7_rst_running", bus.running, 0);
        check("t7_rst_tick", bus.tick, 0);
        check("t7_rst_clr", bus.clr, 0);
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(3);

        // Random buttons (holds of 1..12 cycles), sporadic at_max and resets
        for (int i = 0; i < 3; i++) hold_left[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold_left[i] == 0) begin
                    hold_left[i] = $urandom_range(1, 12);
                    case (i)
                        0:       bus.btn_clear      = 1'($urandom_range(0, 1));
                        1:       bus.btn_start_stop = 1'($urandom_range(0, 1));
                        default: bus.btn_lap        = 1'($urandom_range(0, 1));
                    endcase
                end
                hold_left[i]--;
            end
            bus.at_max = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                compare_all();
                idle(2);
                rst_n = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
